usb_ep_tx_stream: RTL and testbench



---
 rtl/usb_ep_tx_stream.sv | 152 +++++++++++++++
 tb/tb_usb_ep_tx_stream.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_tx_stream.sv
// Streams payload bytes into the EP TX buffer as little-endian 16-bit words,
// then posts a READY descriptor for the target IN endpoint over the register bus.
module usb_ep_tx_stream #(
  parameter logic [3:0] ADDR_MSB = 4'h3,
  parameter logic [9:0] BUF_BASE = 10'h000,
  parameter int         MAX_LEN  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        zlp_req,
  input  logic [3:0]  ep_num,
  input  logic        ep_release,
  output logic [9:0]  ep_tx_addr_0,
  output logic [15:0] ep_tx_data_0,
  output logic        ep_tx_we_0,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_dout,
  output logic        bus_cyc,
  output logic        bus_we,
  input  logic        bus_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    DESC     = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  localparam logic [9:0] MAX_CNT = 10'(MAX_LEN);

  state_e      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [3:0]  ep_q, ep_d;
  logic [7:0]  lo_q, lo_d;
  logic        fin_q, fin_d;
  logic        we_q, we_d;
  logic [9:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        rdy_en_q;

  logic        accept;
  logic        is_last;
  logic [9:0]  idx;
  logic [9:0]  nxt_cnt;

  // fin_q marks the cycle spent flushing the final word before DESC.
  assign s_ready = rdy_en_q & ((state_q == IDLE) | ((state_q == FILL) & ~fin_q));
  assign accept  = s_valid & s_ready;
  assign idx     = (state_q == IDLE) ? 10'd0 : cnt_q;
  assign nxt_cnt = idx + 10'd1;
  assign is_last = s_last | (nxt_cnt == MAX_CNT);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves a value unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    ep_d    = ep_q;
    lo_d    = lo_q;
    fin_d   = fin_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ep_d    = ep_num;
          state_d = FILL;
        end else if (zlp_req && rdy_en_q) begin
          ep_d    = ep_num;
          cnt_d   = 10'd0;
          state_d = DESC;
        end
      end
      FILL: begin
        if (fin_q) begin
          fin_d   = 1'b0;
          state_d = DESC;
        end
      end
      DESC: begin
        if (bus_ack) state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (ep_release) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Byte packing is shared by IDLE (first byte) and FILL (later bytes).
    if (accept) begin
      cnt_d = nxt_cnt;
      if (!idx[0]) begin
        lo_d = s_data;
        if (is_last) begin
          we_d   = 1'b1;
          addr_d = BUF_BASE + (idx >> 1);
          data_d = {8'h00, s_data};
        end
      end else begin
        we_d   = 1'b1;
        addr_d = BUF_BASE + (idx >> 1);
        data_d = {s_data, lo_q};
      end
      if (is_last) fin_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears every register here; the design holds no memory arrays.
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 10'd0;
      ep_q     <= 4'd0;
      lo_q     <= 8'd0;
      fin_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 10'd0;
      data_q   <= 16'd0;
      rdy_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ep_q     <= ep_d;
      lo_q     <= lo_d;
      fin_q    <= fin_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign ep_tx_we_0   = we_q;
  assign ep_tx_addr_0 = addr_q;
  assign ep_tx_data_0 = data_q;

  // Bus fields derive from latched state only, so they cannot move while bus_cyc is high.
  assign bus_cyc  = (state_q == DESC);
  assign bus_we   = bus_cyc;
  assign bus_addr = bus_cyc ? {ADDR_MSB, 4'b1000, ep_q, 4'h4} : 16'h0000;
  assign bus_dout = bus_cyc ? {3'b001, 3'b000, cnt_q} : 16'h0000;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_usb_ep_tx_stream.sv
// Self-checking bench for usb_ep_tx_stream: directed corner cases plus randomized
// packets checked against a byte-list model of buffer words and descriptors.
module tb_usb_ep_tx_stream;

  localparam logic [3:0] ADDR_MSB = 4'h3;
  localparam logic [9:0] BUF_BASE = 10'h040;
  localparam int         MAX_LEN  = 64;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        zlp_req;
  logic [3:0]  ep_num;
  logic        ep_release;
  logic [9:0]  ep_tx_addr_0;
  logic [15:0] ep_tx_data_0;
  logic        ep_tx_we_0;
  logic [15:0] bus_addr;
  logic [15:0] bus_dout;
  logic        bus_cyc;
  logic        bus_we;
  logic        bus_ack;
  logic        busy;

  usb_ep_tx_stream #(
    .ADDR_MSB(ADDR_MSB),
    .BUF_BASE(BUF_BASE),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .zlp_req     (zlp_req),
    .ep_num      (ep_num),
    .ep_release  (ep_release),
    .ep_tx_addr_0(ep_tx_addr_0),
    .ep_tx_data_0(ep_tx_data_0),
    .ep_tx_we_0  (ep_tx_we_0),
    .bus_addr    (bus_addr),
    .bus_dout    (bus_dout),
    .bus_cyc     (bus_cyc),
    .bus_we      (bus_we),
    .bus_ack     (bus_ack),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_we_cyc = -1;
  int desc_cyc    = -1;
  logic bus_cyc_prev = 1'b0;
  logic [25:0] wq[$];
  logic [7:0]  pkt[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer-write and descriptor-start monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ep_tx_we_0 === 1'b1) begin
      wq.push_back({ep_tx_addr_0, ep_tx_data_0});
      last_we_cyc = cyc;
    end
    if (bus_cyc === 1'b1 && bus_cyc_prev !== 1'b1) desc_cyc = cyc;
    bus_cyc_prev = bus_cyc;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: word k holds bytes 2k (low) and 2k+1 (high), high byte zero past the end.
  function automatic logic [25:0] exp_word(input int k, input int n);
    logic [7:0] hi;
    hi = (2 * k + 1 < n) ? pkt[2 * k + 1] : 8'h00;
    return {BUF_BASE + 10'(k), hi, pkt[2 * k]};
  endfunction

  task automatic send(input bit with_last, input int rel_at, output int acc);
    bit got;
    acc = 0;
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == rel_at) begin
        ep_release = 1'b1;
        tick();
        ep_release = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) tick();
      s_valid = 1'b1;
      s_data  = pkt[i];
      s_last  = with_last && (i == pkt.size() - 1);
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        got = s_ready;
        tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!got) break;
      acc++;
      if (i == 0) ep_num = ~ep_num;
    end
  endtask

  task automatic desc(input logic [3:0] ep, input int n, input int delay, input bit stray);
    logic [15:0] ea;
    logic [15:0] ed;
    ea = {ADDR_MSB, 4'b1000, ep, 4'h4};
    ed = {3'b001, 3'b000, 10'(n)};
    for (int t = 0; t < 12 && bus_cyc !== 1'b1; t++) tick();
    check("desc_enter", 32'(bus_cyc), 32'd1);
    check("desc_we",    32'(bus_we),  32'd1);
    check("desc_addr",  32'(bus_addr), 32'(ea));
    check("desc_dout",  32'(bus_dout), 32'(ed));
    check("desc_ready", 32'(s_ready), 32'd0);
    for (int d = 0; d < delay; d++) begin
      tick();
      check("hold_cyc",  32'(bus_cyc),  32'd1);
      check("hold_addr", 32'(bus_addr), 32'(ea));
      check("hold_dout", 32'(bus_dout), 32'(ed));
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("ack_cyc_drop", 32'(bus_cyc), 32'd0);
    check("ack_busy",     32'(busy),    32'd1);
    if (stray) begin
      bus_ack = 1'b1;
      zlp_req = 1'b1;
      tick();
      bus_ack = 1'b0;
      zlp_req = 1'b0;
      check("stray_cyc",  32'(bus_cyc), 32'd0);
      check("stray_busy", 32'(busy),    32'd1);
    end
    repeat ($urandom_range(0, 2)) tick();
    check("wait_ready", 32'(s_ready), 32'd0);
    ep_release = 1'b1;
    tick();
    ep_release = 1'b0;
    check("rel_busy",  32'(busy),    32'd0);
    check("rel_ready", 32'(s_ready), 32'd1);
  endtask

  // Expects pkt filled; n accepted bytes = first s_last or MAX_LEN.
  task automatic run_pkt(input logic [3:0] ep, input bit with_last, input int rel_at,
                         input int delay, input bit stray);
    int base;
    int acc;
    int n;
    n = (pkt.size() < MAX_LEN) ? pkt.size() : MAX_LEN;
    ep_num   = ep;
    base     = wq.size();
    desc_cyc = -1;
    send(with_last, rel_at, acc);
    check("accepted", 32'(acc), 32'(n));
    desc(ep, n, delay, stray);
    check("wr_count", 32'(wq.size() - base), 32'((n + 1) / 2));
    for (int k = 0; k < (n + 1) / 2 && base + k < wq.size(); k++)
      check("wr_word", 32'(wq[base + k]), 32'(exp_word(k, n)));
    check("desc_timing", 32'(desc_cyc - last_we_cyc), 32'd1);
  endtask

  task automatic fill_rand(input int len);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
  endtask

  initial begin
    int base;
    int acc;
    int zc;
    bit wl;
    int len;
    int rel;

    rst_n = 1'b0; s_data = 8'h00; s_valid = 1'b1; s_last = 1'b0;
    zlp_req = 1'b0; ep_num = 4'h0; ep_release = 1'b0; bus_ack = 1'b0;
    repeat (3) tick();
    check("rst_s_ready",  32'(s_ready),      32'd0);
    check("rst_we",       32'(ep_tx_we_0),   32'd0);
    check("rst_bus_cyc",  32'(bus_cyc),      32'd0);
    check("rst_bus_we",   32'(bus_we),       32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_tx_addr",  32'(ep_tx_addr_0), 32'd0);
    check("rst_tx_data",  32'(ep_tx_data_0), 32'd0);
    check("rst_bus_addr", 32'(bus_addr),     32'd0);
    check("rst_bus_dout", 32'(bus_dout),     32'd0);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    check("rst_ready_before_edge", 32'(s_ready), 32'd0);
    tick();
    check("rst_ready_after_edge", 32'(s_ready), 32'd1);

    // Three-byte packet, odd length.
    pkt = '{8'h11, 8'h22, 8'h33};
    base = wq.size();
    run_pkt(4'd2, 1'b1, -1, 1, 1'b0);
    if (wq.size() >= base + 2) begin
      check("p3_word0", 32'(wq[base]),     32'({10'h040, 16'h2211}));
      check("p3_word1", 32'(wq[base + 1]), 32'({10'h041, 16'h0033}));
    end

    // Zero-length packet.
    base = wq.size();
    desc_cyc = -1;
    ep_num = 4'd1;
    zlp_req = 1'b1;
    zc = cyc;
    tick();
    zlp_req = 1'b0;
    check("zlp_cyc_next", 32'(bus_cyc), 32'd1);
    desc(4'd1, 0, 2, 1'b0);
    check("zlp_no_writes", 32'(wq.size() - base), 32'd0);
    check("zlp_timing", 32'(desc_cyc - zc), 32'd1);

    // Overflow: 70 bytes with no s_last truncate at MAX_LEN.
    fill_rand(70);
    run_pkt(4'($urandom), 1'b0, -1, 0, 1'b0);

    // Slow ack with stray ack/zlp in WAIT_REL, and ep_release pulsed mid-FILL.
    fill_rand(9);
    run_pkt(4'd5, 1'b1, 4, 5, 1'b1);

    // Byte and zlp_req together in IDLE: the byte wins.
    base = wq.size();
    ep_num  = 4'd7;
    s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b1; zlp_req = 1'b1;
    check("both_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0; s_last = 1'b0; zlp_req = 1'b0;
    desc(4'd7, 1, 0, 1'b0);
    check("both_wr_count", 32'(wq.size() - base), 32'd1);
    if (wq.size() > base) check("both_word", 32'(wq[base]), 32'({BUF_BASE, 16'h005A}));

    // Reset mid-FILL abandons the packet and restarts indexing.
    fill_rand(3);
    base = wq.size();
    ep_num = 4'd3;
    send(1'b0, -1, acc);
    check("mid_acc", 32'(acc), 32'd3);
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(busy),       32'd0);
    check("mid_rst_we",   32'(ep_tx_we_0), 32'd0);
    repeat (3) tick();
    check("mid_wr_count", 32'(wq.size() - base), 32'd1);
    fill_rand(4);
    run_pkt(4'd9, 1'b1, -1, 0, 1'b0);

    // Reset during DESC drops the bus cycle at that edge.
    fill_rand(2);
    ep_num = 4'd6;
    send(1'b1, -1, acc);
    for (int t = 0; t < 12 && bus_cyc !== 1'b1; t++) tick();
    check("rd_cyc_up", 32'(bus_cyc), 32'd1);
    base = wq.size();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rd_cyc",  32'(bus_cyc),  32'd0);
    check("rd_busy", 32'(busy),     32'd0);
    check("rd_addr", 32'(bus_addr), 32'd0);
    tick();
    check("rd_ready", 32'(s_ready), 32'd1);
    repeat (5) tick();
    check("rd_quiet_cyc", 32'(bus_cyc), 32'd0);
    check("rd_quiet_wr",  32'(wq.size() - base), 32'd0);

    // Randomized packets.
    for (int p = 0; p < 10; p++) begin
      wl  = ($urandom_range(0, 2) != 0);
      len = wl ? int'($urandom_range(1, MAX_LEN)) : int'($urandom_range(MAX_LEN, MAX_LEN + 6));
      rel = (len > 2 && $urandom_range(0, 1) == 1) ?
            int'($urandom_range(1, ((len < MAX_LEN) ? len : MAX_LEN) - 1)) : -1;
      fill_rand(len);
      run_pkt(4'($urandom), wl, rel, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
